digit_serial_addsub: RTL

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

---
 rtl/addsub_pkg.sv | 13 +
 rtl/digit_adder.sv | 26 ++
 rtl/digit_serial_addsub.sv | 124 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the digit-serial add/subtract block.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple adder made of full-adder cells; also exports the carry into
// the most significant bit so the parent can form signed overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial signed adder/subtractor, DIGIT bits per clock, LSB slice first.
// Optional macro ADDSUB_OVF_EN enables the signed overflow output.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one DIGIT slice added per cycle
// DONE    | result valid, done pulses; start here begins the next operation
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, bm_sh, acc;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [DIGIT-1:0] s_dig;
    logic             cout_dig;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH:0]   sum_q;
    logic             accept, last;

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last   = (state_q == ST_RUN) && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = start ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

`ifdef ADDSUB_OVF_EN
    logic cmsb_dig;
    logic ovf_q;

    digit_adder #(.DIGIT(DIGIT)) u_adder (
        .x(a_sh[DIGIT-1:0]), .y(bm_sh[DIGIT-1:0]), .cin(carry_q),
        .s(s_dig), .cout(cout_dig), .cmsb(cmsb_dig)
    );

    always_ff @(posedge clk) begin
        if (reset)     ovf_q <= 1'b0;
        else if (last) ovf_q <= cmsb_dig ^ cout_dig;
    end

    assign ovf = ovf_q;
`else
    logic cmsb_nc;

    digit_adder #(.DIGIT(DIGIT)) u_adder (
        .x(a_sh[DIGIT-1:0]), .y(bm_sh[DIGIT-1:0]), .cin(carry_q),
        .s(s_dig), .cout(cout_dig), .cmsb(cmsb_nc)
    );

    assign ovf = 1'b0;
`endif

    // New slice enters at the top; after NDIG shifts acc holds the whole result.
    assign res_next = WIDTH'({s_dig, acc} >> DIGIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh    <= '0;
            bm_sh   <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
        end else if (accept) begin
            a_sh    <= clear ? '0 : a;
            bm_sh   <= clear ? '0 : (b ^ {WIDTH{sub}});
            carry_q <= sub & ~clear;
            idx_q   <= '0;
        end else if (state_q == ST_RUN) begin
            a_sh    <= a_sh >> DIGIT;
            bm_sh   <= bm_sh >> DIGIT;
            acc     <= res_next;
            carry_q <= cout_dig;
            if (last) begin
                sum_q <= {a_sh[DIGIT-1] ^ bm_sh[DIGIT-1] ^ cout_dig, res_next};
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum = sum_q;

endmodule
